// File: rtl/encode_sk_stream.sv
// Streaming ByteEncode_12 for the secret key s. Coefficients are reduced to
// [0, q-1], and each pair of coefficients is packed into three bytes on a valid/ready stream.
module encode_sk_stream #(
    parameter int KYBER_N       = 256,
    parameter int KYBER_K       = 3,
    parameter int KYBER_R_WIDTH = 12,
    parameter int KYBER_Q       = 3329
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [KYBER_R_WIDTH-1:0] coeff_in,
    input  logic                     coeff_valid,
    output logic                     coeff_ready,
    output logic [7:0]               byte_out,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic                     byte_last,
    output logic                     busy,
    output logic                     done
);

    localparam int NUM_COEFFS = KYBER_K * KYBER_N;
    localparam int NUM_BYTES  = NUM_COEFFS * KYBER_R_WIDTH / 8;
    localparam int CW         = $clog2(NUM_COEFFS);
    localparam int BW         = $clog2(NUM_BYTES);

    localparam logic [CW-1:0]            LAST_COEFF = CW'(NUM_COEFFS - 1);
    localparam logic [BW-1:0]            LAST_BYTE  = BW'(NUM_BYTES - 1);
    localparam logic [KYBER_R_WIDTH-1:0] Q          = KYBER_R_WIDTH'(KYBER_Q);

    typedef enum logic [2:0] {
        IDLE,
        GET_A,
        GET_B,
        EMIT0,
        EMIT1,
        EMIT2
    } state_t;

    state_t                   state;
    logic [CW-1:0]            coeff_cnt;
    logic [BW-1:0]            byte_cnt;
    logic [KYBER_R_WIDTH-1:0] a;
    logic [KYBER_R_WIDTH-1:0] b;

    // A 12-bit input is below 2q, so one conditional subtract gives a canonical result.
    function automatic logic [KYBER_R_WIDTH-1:0] red(input logic [KYBER_R_WIDTH-1:0] x);
        return (x >= Q) ? x - Q : x;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            coeff_cnt   <= '0;
            byte_cnt    <= '0;
            a           <= '0;
            b           <= '0;
            coeff_ready <= 1'b0;
            byte_out    <= 8'h00;
            byte_valid  <= 1'b0;
            byte_last   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= GET_A;
                        busy        <= 1'b1;
                        coeff_ready <= 1'b1;
                        coeff_cnt   <= '0;
                        byte_cnt    <= '0;
                    end
                end
                GET_A: begin
                    if (coeff_valid) begin
                        a         <= red(coeff_in);
                        coeff_cnt <= coeff_cnt + CW'(1);
                        state     <= GET_B;
                    end
                end
                GET_B: begin
                    // Byte 0 depends only on a, so it can be presented on the next cycle.
                    if (coeff_valid) begin
                        b           <= red(coeff_in);
                        coeff_ready <= 1'b0;
                        byte_valid  <= 1'b1;
                        byte_out    <= a[7:0];
                        byte_last   <= (byte_cnt == LAST_BYTE);
                        state       <= EMIT0;
                    end
                end
                EMIT0: begin
                    if (byte_ready) begin
                        byte_out  <= {b[3:0], a[11:8]};
                        byte_cnt  <= byte_cnt + BW'(1);
                        byte_last <= (byte_cnt + BW'(1) == LAST_BYTE);
                        state     <= EMIT1;
                    end
                end
                EMIT1: begin
                    if (byte_ready) begin
                        byte_out  <= b[11:4];
                        byte_cnt  <= byte_cnt + BW'(1);
                        byte_last <= (byte_cnt + BW'(1) == LAST_BYTE);
                        state     <= EMIT2;
                    end
                end
                EMIT2: begin
                    if (byte_ready) begin
                        byte_valid <= 1'b0;
                        byte_out   <= 8'h00;
                        byte_last  <= 1'b0;
                        if (coeff_cnt == LAST_COEFF) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            byte_cnt    <= byte_cnt + BW'(1);
                            coeff_cnt   <= coeff_cnt + CW'(1);
                            coeff_ready <= 1'b1;
                            state       <= GET_A;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
